// File: rtl/ntt_sequencer.sv
// Control sequencer for the NTT core array: stage walk, bank addressing, delayed write strobes.
// Optional inverse transform support is enabled by defining NTT_SEQ_INTT_EN.
module ntt_sequencer #(
   parameter int  LOG_N          = 15,
   parameter int  LOG_CORE_COUNT = 5,
   parameter int  PIPE_LATENCY   = 8,
   localparam int AW             = LOG_N - LOG_CORE_COUNT - 1,
   localparam int D              = 1 << AW,
   localparam int SW             = $clog2(LOG_N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          inverse,
   output logic          busy,
   output logic          done,
   output logic [1:0]    mode,
   output logic [SW-1:0] log_m,
   output logic [SW-1:0] log_t,
   output logic [AW:0]   i,
   output logic [AW-1:0] upper_read_address,
   output logic [AW-1:0] lower_read_address,
   output logic [AW-1:0] write_address,
   output logic          write_enable
);

   localparam int CW = $clog2(PIPE_LATENCY + 1);
   localparam logic [SW-1:0] LAST = SW'(LOG_N - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] r;
   logic [CW-1:0] dcnt;
   logic          accept;
   logic          last_read;
   logic          last_drain;
   logic          last_stage;
   logic [SW-1:0] first_m;
   logic [SW-1:0] next_m;
   logic [AW:0]   pipe [PIPE_LATENCY];

   assign accept     = (state == IDLE) && start;
   assign last_read  = (r == AW'(D - 1));
   assign last_drain = (dcnt == CW'(PIPE_LATENCY - 1));

`ifdef NTT_SEQ_INTT_EN
   logic inv_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         inv_q <= 1'b0;
      end else if (accept) begin
         inv_q <= inverse;
      end
   end

   assign mode       = {1'b0, inv_q};
   assign first_m    = inverse ? LAST : '0;
   assign last_stage = inv_q ? (log_m == '0) : (log_m == LAST);
   assign next_m     = inv_q ? log_m - SW'(1) : log_m + SW'(1);
`else
   logic unused_inverse;

   assign unused_inverse = inverse;
   assign mode           = 2'b00;
   assign first_m        = '0;
   assign last_stage     = (log_m == LAST);
   assign next_m         = log_m + SW'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start) state_nxt = READ;
         READ:  if (last_read) state_nxt = DRAIN;
         DRAIN: if (last_drain) state_nxt = last_stage ? DONE : READ;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // r stays at zero outside READ so every stage starts from address 0
   always_ff @(posedge clk) begin
      if (rst) begin
         r     <= '0;
         dcnt  <= '0;
         log_m <= '0;
      end else if (accept) begin
         r     <= '0;
         dcnt  <= '0;
         log_m <= first_m;
      end else if (state == READ) begin
         r <= last_read ? '0 : r + AW'(1);
      end else if (state == DRAIN) begin
         dcnt <= last_drain ? '0 : dcnt + CW'(1);
         if (last_drain && !last_stage) begin
            log_m <= next_m;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PIPE_LATENCY; k++) begin
            pipe[k] <= '0;
         end
      end else begin
         pipe[0] <= {state == READ, r};
         for (int k = 1; k < PIPE_LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
         end
      end
   end

   assign busy               = (state == READ) || (state == DRAIN);
   assign done               = (state == DONE);
   assign log_t              = LAST - log_m;
   assign i                  = {1'b0, r};
   assign upper_read_address = r;
   assign lower_read_address = r;
   assign write_enable       = pipe[PIPE_LATENCY-1][AW];
   assign write_address      = pipe[PIPE_LATENCY-1][AW-1:0];

endmodule

// File: tb/tb_ntt_sequencer.sv
// Directed bench for ntt_sequencer at LOG_N=5, LOG_CORE_COUNT=1, PIPE_LATENCY=2.
// Stage = 10 cycles, done at cycle 51 after an accepted start.
module tb_ntt_sequencer;

   localparam int LOG_N = 5;
   localparam int LCC   = 1;
   localparam int PL    = 2;

`ifdef NTT_SEQ_INTT_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       inverse;
   logic       busy;
   logic       done;
   logic [1:0] mode;
   logic [2:0] log_m;
   logic [2:0] log_t;
   logic [3:0] i;
   logic [2:0] ura;
   logic [2:0] lra;
   logic [2:0] wa;
   logic       we;

   int n_chk  = 0;
   int n_fail = 0;

   ntt_sequencer #(
      .LOG_N(LOG_N),
      .LOG_CORE_COUNT(LCC),
      .PIPE_LATENCY(PL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .inverse(inverse),
      .busy(busy),
      .done(done),
      .mode(mode),
      .log_m(log_m),
      .log_t(log_t),
      .i(i),
      .upper_read_address(ura),
      .lower_read_address(lra),
      .write_address(wa),
      .write_enable(we)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".done"}, done, 0);
      chk({tag, ".we"}, we, 0);
      chk({tag, ".wa"}, wa, 0);
      chk({tag, ".mode"}, mode, 0);
      chk({tag, ".log_m"}, log_m, 0);
      chk({tag, ".log_t"}, log_t, 4);
      chk({tag, ".i"}, i, 0);
      chk({tag, ".ura"}, ura, 0);
      chk({tag, ".lra"}, lra, 0);
   endtask

   // Entered in cycle 0 with start already driven; checks cycles 1..52.
   // pm: 0 = start dropped, 1 = start/inverse pulses at 5..40, 2 = start held
   task automatic run(input int pm, input bit inv_run);
      int  s;
      int  off;
      int  em;
      int  writes;
      bit  inv_on;
      inv_on = inv_run && INV_EN;
      writes = 0;
      for (int c = 1; c <= 52; c++) begin
         step();
         start   = (pm == 2) || (pm == 1 && c >= 5 && c <= 40);
         inverse = (pm == 1 && c >= 5 && c <= 40);
         if (c <= 50) begin
            s   = (c - 1) / 10;
            off = (c - 1) % 10;
            em  = inv_on ? 4 - s : s;
            chk("busy", busy, 1);
            chk("done", done, 0);
            chk("log_m", log_m, em);
            chk("log_t", log_t, 4 - em);
            chk("mode", mode, inv_on ? 1 : 0);
            if (off < 8) begin
               chk("upper_addr", ura, off);
               chk("lower_addr", lra, off);
               chk("i", i, off);
            end
            chk("write_enable", we, (off >= 2) ? 1 : 0);
            if (off >= 2) chk("write_addr", wa, off - 2);
            if (we === 1'b1) writes++;
         end else if (c == 51) begin
            chk("done_pulse", done, 1);
            chk("busy_at_done", busy, 0);
            chk("we_at_done", we, 0);
         end else begin
            chk("done_after", done, 0);
            chk("busy_after", busy, 0);
         end
      end
      chk("write_count", writes, 40);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      inverse = 1'b0;
      step();
      step();
      chk_reset("reset");
      rst = 1'b0;
      step();
      chk_reset("idle");

      // forward run with ignored start/inverse pulses mid-run
      start = 1'b1;
      run(1, 1'b0);

      // inverse request; inverse dropped after the accepting cycle
      start   = 1'b1;
      inverse = 1'b1;
      run(0, 1'b1);

      // start held high: second run accepted in cycle 52, done at 103
      start = 1'b1;
      run(2, 1'b0);
      run(0, 1'b0);

      // reset during stage 1 READ with writes in flight
      start   = 1'b1;
      inverse = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         step();
         start   = 1'b0;
         inverse = 1'b0;
      end
      chk("pre_abort_we", we, 1);
      rst = 1'b1;
      step();
      chk_reset("abort");
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step();
         chk("post_abort_we", we, 0);
         chk("post_abort_done", done, 0);
         chk("post_abort_busy", busy, 0);
      end

      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_busy", busy, 1);
      chk("restart_addr", ura, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
